// File: rtl/daisy_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | daisy_pkg                                                                |
// | Shared definitions for the daisy-chain receiver: training FSM state      |
// | encoding, default training word and error-counter width.                |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package daisy_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WAIT   = 3'd1,
    ST_CHECK  = 3'd2,
    ST_SLIP   = 3'd3,
    ST_LOCKED = 3'd4
  } daisy_state_t;

  localparam logic [15:0] DEF_TRAIN_PAT = 16'h00FF;
  localparam int          ERR_CNT_W     = 16;

endpackage
`default_nettype wire

// File: rtl/red_pitaya_daisy_word_asm.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | red_pitaya_daisy_word_asm                                                |
// | Assembles SER_W-bit chunks into SER_W*CHUNKS-bit candidate words.        |
// | Ports:                                                                   |
// |   clk_i, rstn_i : clock, synchronous active-low reset                    |
// |   ser_dat_i     : raw chunk, MSB earliest                                |
// |   slip_i        : hold the phase counter for one cycle (chunk slip)      |
// |   strobe_o      : high when the current chunk completes a word           |
// |   cand_o        : {oldest chunk, ..., current chunk}                     |
// | Requires CHUNKS >= 2.                                                    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module red_pitaya_daisy_word_asm #(
  parameter int SER_W  = 4,
  parameter int CHUNKS = 4
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic [SER_W-1:0]          ser_dat_i,
  input  logic                      slip_i,
  output logic                      strobe_o,
  output logic [SER_W*CHUNKS-1:0]   cand_o
);

  localparam int WORD_W = SER_W * CHUNKS;
  localparam int HIST_W = WORD_W - SER_W;
  localparam int PH_W   = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

  logic [HIST_W-1:0] hist;
  logic [PH_W-1:0]   ph;
  logic              ph_last;

  assign ph_last  = (ph == PH_W'(CHUNKS - 1));
  assign strobe_o = ph_last;
  // The current chunk is included combinationally so the word is judged in
  // the same cycle its last chunk arrives.
  assign cand_o   = {hist, ser_dat_i};

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      hist <= '0;
      ph   <= '0;
    end else begin
      hist <= cand_o[HIST_W-1:0];
      // Holding ph delays every later strobe by one chunk.
      if (!slip_i) begin
        ph <= ph_last ? '0 : ph + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/red_pitaya_daisy_rx_align.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | red_pitaya_daisy_rx_align                                                |
// | Word alignment and link training for the daisy-chain receiver.          |
// | Ports:                                                                   |
// |   clk_i, rstn_i  : parallel clock, synchronous active-low reset          |
// |   ser_dat_i      : raw ISERDES chunk                                     |
// |   bitslip_o      : one-cycle bitslip request to the ISERDES              |
// |   cfg_train_i    : training enable                                       |
// |   sync_mode_i    : bypass, raw chunk forwarded every cycle               |
// |   cfg_trained_o  : link locked                                           |
// |   cfg_fail_o     : sticky, every alignment tried without lock            |
// |   cfg_err_cnt_o  : saturating mismatch count while locked and training   |
// |   par_dv_o/par_dat_o : aligned word output                               |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module red_pitaya_daisy_rx_align
  import daisy_pkg::*;
#(
  parameter int                      SER_W     = 4,
  parameter int                      CHUNKS    = 4,
  parameter logic [SER_W*CHUNKS-1:0] TRAIN_PAT = DEF_TRAIN_PAT,
  parameter int                      SLIP_WAIT = 8,
  parameter int                      LOCK_CNT  = 4,
  parameter int                      LOSS_CNT  = 4
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic [SER_W-1:0]          ser_dat_i,
  output logic                      bitslip_o,
  input  logic                      cfg_train_i,
  input  logic                      sync_mode_i,
  output logic                      cfg_trained_o,
  output logic                      cfg_fail_o,
  output logic [ERR_CNT_W-1:0]      cfg_err_cnt_o,
  output logic                      par_dv_o,
  output logic [SER_W*CHUNKS-1:0]   par_dat_o
);

  localparam int WORD_W   = SER_W * CHUNKS;
  localparam int ATTEMPTS = SER_W * CHUNKS;
  localparam int BC_W     = (SER_W > 1) ? $clog2(SER_W) : 1;
  localparam int AT_W     = (ATTEMPTS > 1) ? $clog2(ATTEMPTS) : 1;
  localparam int MC_W     = $clog2(LOCK_CNT + 1);
  localparam int LC_W     = $clog2(LOSS_CNT + 1);

  daisy_state_t      state;
  logic [7:0]        wait_cnt;
  logic [BC_W-1:0]   bit_cnt;
  logic [MC_W-1:0]   match_cnt;
  logic [LC_W-1:0]   loss_cnt;
  logic [AT_W-1:0]   attempt;

  logic              strobe;
  logic [WORD_W-1:0] cand;
  logic              cand_ok;
  logic              chunk_slip;
  logic              abort;

  // Every SER_W-th bitslip the ISERDES has rotated through a whole chunk,
  // so the word boundary is moved by one chunk instead.
  assign chunk_slip = (state == ST_SLIP) && cfg_train_i &&
                      (bit_cnt == BC_W'(SER_W - 1));
  assign cand_ok    = (cand == TRAIN_PAT);
  // Dropping training during the search wins over anything else that cycle.
  assign abort      = !cfg_train_i &&
                      ((state == ST_WAIT) || (state == ST_CHECK) || (state == ST_SLIP));

  red_pitaya_daisy_word_asm #(
    .SER_W  (SER_W),
    .CHUNKS (CHUNKS)
  ) u_word_asm (
    .clk_i     (clk_i),
    .rstn_i    (rstn_i),
    .ser_dat_i (ser_dat_i),
    .slip_i    (chunk_slip),
    .strobe_o  (strobe),
    .cand_o    (cand)
  );

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state         <= ST_IDLE;
      wait_cnt      <= '0;
      bit_cnt       <= '0;
      match_cnt     <= '0;
      loss_cnt      <= '0;
      attempt       <= '0;
      bitslip_o     <= 1'b0;
      cfg_trained_o <= 1'b0;
      cfg_fail_o    <= 1'b0;
      cfg_err_cnt_o <= '0;
      par_dv_o      <= 1'b0;
      par_dat_o     <= '0;
    end else begin
      bitslip_o <= 1'b0;
      if (!cfg_train_i) begin
        cfg_fail_o <= 1'b0;
      end

      // Output path: bypass overrides aligned delivery.
      if (sync_mode_i) begin
        par_dv_o  <= 1'b1;
        par_dat_o <= WORD_W'(ser_dat_i);
      end else if ((state == ST_LOCKED) && !cfg_train_i && strobe) begin
        par_dv_o  <= 1'b1;
        par_dat_o <= cand;
      end else begin
        par_dv_o  <= 1'b0;
      end

      if (abort) begin
        state     <= ST_IDLE;
        wait_cnt  <= '0;
        bit_cnt   <= '0;
        match_cnt <= '0;
        attempt   <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            bit_cnt   <= '0;
            match_cnt <= '0;
            attempt   <= '0;
            if (cfg_train_i) begin
              state <= ST_WAIT;
            end
          end

          ST_WAIT: begin
            if (wait_cnt == 8'(SLIP_WAIT - 1)) begin
              wait_cnt <= '0;
              state    <= ST_CHECK;
            end else begin
              wait_cnt <= wait_cnt + 1'b1;
            end
          end

          ST_CHECK: begin
            if (strobe) begin
              if (cand_ok) begin
                if (match_cnt == MC_W'(LOCK_CNT - 1)) begin
                  match_cnt     <= '0;
                  loss_cnt      <= '0;
                  cfg_trained_o <= 1'b1;
                  state         <= ST_LOCKED;
                end else begin
                  match_cnt <= match_cnt + 1'b1;
                end
              end else begin
                match_cnt <= '0;
                state     <= ST_SLIP;
              end
            end
          end

          ST_SLIP: begin
            bitslip_o <= 1'b1;
            bit_cnt   <= (bit_cnt == BC_W'(SER_W - 1)) ? '0 : bit_cnt + 1'b1;
            if (attempt == AT_W'(ATTEMPTS - 1)) begin
              attempt    <= '0;
              cfg_fail_o <= 1'b1;
            end else begin
              attempt <= attempt + 1'b1;
            end
            state <= ST_WAIT;
          end

          ST_LOCKED: begin
            if (cfg_train_i && strobe) begin
              if (cand_ok) begin
                loss_cnt <= '0;
              end else begin
                if (cfg_err_cnt_o != '1) begin
                  cfg_err_cnt_o <= cfg_err_cnt_o + 1'b1;
                end
                if (loss_cnt == LC_W'(LOSS_CNT - 1)) begin
                  loss_cnt      <= '0;
                  cfg_trained_o <= 1'b0;
                  state         <= ST_SLIP;
                end else begin
                  loss_cnt <= loss_cnt + 1'b1;
                end
              end
            end
          end

          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire
